issue_queue_sel: RTL and testbench

- Parametrised successor of the 2-wide wakeup-only issue queue.
- Allocates free entries internally on 2-wide dispatch and wakes sources via 2 broadcast tags with per-source latency countdown.
- Selects one ready instruction per issue port (2 ports) with a valid/ready handshake to the FUs.
- Squashes wrong-path entries on branch mispredict using ROB number plus sorting bit.
- Sits between dispatch and FU operand read.

---
 rtl/issue_queue_sel.sv | 203 ++++++++++++++++++++
 tb/tb_issue_queue_sel.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/issue_queue_sel.sv
// Issue queue: 2-wide dispatch into free entries, 2-tag wakeup with per-source latency countdown,
// one select per issue port, ROB-age squash on flush. Macro ISSUE_QUEUE_AGE_SELECT_EN: oldest-first select.
module issue_queue_sel #(
  parameter int IQ_DEPTH  = 16,
  parameter int PREG_W    = 6,
  parameter int ROB_W     = 6,
  parameter int LAT_W     = 3,
  parameter int PAYLOAD_W = 32
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [1:0]                disp_valid,
  output logic                      disp_ready,
  input  logic [1:0]                disp_port,
  input  logic [2*PREG_W-1:0]       disp_src1,
  input  logic [2*PREG_W-1:0]       disp_src2,
  input  logic [1:0]                disp_rdy1,
  input  logic [1:0]                disp_rdy2,
  input  logic [2*LAT_W-1:0]        disp_dly1,
  input  logic [2*LAT_W-1:0]        disp_dly2,
  input  logic [2*PREG_W-1:0]       disp_dst,
  input  logic [2*ROB_W-1:0]        disp_rob,
  input  logic [1:0]                disp_sb,
  input  logic [2*PAYLOAD_W-1:0]    disp_payload,
  input  logic [1:0]                wk_valid,
  input  logic [2*PREG_W-1:0]       wk_tag,
  input  logic                      flush,
  input  logic [ROB_W-1:0]          flush_rob,
  input  logic                      flush_sb,
  output logic [1:0]                iss_valid,
  input  logic [1:0]                iss_ready,
  output logic [2*PREG_W-1:0]       iss_src1,
  output logic [2*PREG_W-1:0]       iss_src2,
  output logic [2*PREG_W-1:0]       iss_dst,
  output logic [2*ROB_W-1:0]        iss_rob,
  output logic [2*PAYLOAD_W-1:0]    iss_payload,
  output logic [$clog2(IQ_DEPTH):0] occupancy
);
  localparam int IDX_W = $clog2(IQ_DEPTH);
  localparam int CNT_W = IDX_W + 1;

  typedef struct packed {
    logic                 valid;
    logic                 port;
    logic [PREG_W-1:0]    src1;
    logic [PREG_W-1:0]    src2;
    logic                 m1;
    logic                 m2;
    logic [LAT_W-1:0]     c1;
    logic [LAT_W-1:0]     c2;
    logic [LAT_W-1:0]     dly1;
    logic [LAT_W-1:0]     dly2;
    logic [PREG_W-1:0]    dst;
    logic [ROB_W-1:0]     rob;
    logic                 sb;
    logic [PAYLOAD_W-1:0] payload;
  } entry_t;

  entry_t ent_q [IQ_DEPTH];
  entry_t ent_d [IQ_DEPTH];
  entry_t new_e;

  logic [IQ_DEPTH-1:0]       req;
  logic [1:0]                sel_found;
  logic [1:0][IDX_W-1:0]     sel_idx;
  logic                      sel_take;
  logic [1:0]                alloc_found;
  logic [1:0][IDX_W-1:0]     alloc_idx;
  logic [CNT_W-1:0]          occ;

  function automatic logic wk_hit(input logic [PREG_W-1:0] tag, input logic [1:0] wv,
                                  input logic [2*PREG_W-1:0] wt);
    return (wv[0] && (wt[0 +: PREG_W] == tag)) || (wv[1] && (wt[PREG_W +: PREG_W] == tag));
  endfunction

  // Sorting bit flips on ROB wrap, so a differing bit reverses the index comparison.
  function automatic logic is_older(input logic [ROB_W-1:0] rob_a, input logic sb_a,
                                    input logic [ROB_W-1:0] rob_b, input logic sb_b);
    return (sb_a == sb_b) ? (rob_a < rob_b) : (rob_a > rob_b);
  endfunction

  always_comb begin
    req         = '0;
    occ         = '0;
    alloc_found = '0;
    alloc_idx   = '0;
    for (int i = 0; i < IQ_DEPTH; i++) begin
      req[i] = ent_q[i].valid && ent_q[i].m1 && (ent_q[i].c1 == '0)
                              && ent_q[i].m2 && (ent_q[i].c2 == '0);
      if (ent_q[i].valid) begin
        occ = occ + CNT_W'(1);
      end else if (!alloc_found[0]) begin
        alloc_found[0] = 1'b1;
        alloc_idx[0]   = IDX_W'(i);
      end else if (!alloc_found[1]) begin
        alloc_found[1] = 1'b1;
        alloc_idx[1]   = IDX_W'(i);
      end
    end
  end

  always_comb begin
    sel_found = '0;
    sel_idx   = '0;
    sel_take  = 1'b0;
    for (int p = 0; p < 2; p++) begin
      for (int i = 0; i < IQ_DEPTH; i++) begin
        sel_take = req[i] && (ent_q[i].port == 1'(p)) && !sel_found[p];
`ifdef ISSUE_QUEUE_AGE_SELECT_EN
        sel_take = sel_take || (req[i] && (ent_q[i].port == 1'(p)) && sel_found[p] &&
                   is_older(ent_q[i].rob, ent_q[i].sb, ent_q[sel_idx[p]].rob, ent_q[sel_idx[p]].sb));
`endif
        if (sel_take) begin
          sel_found[p] = 1'b1;
          sel_idx[p]   = IDX_W'(i);
        end
      end
    end
  end

  // Handshake: iss_valid[p] never depends on iss_ready[p]; the entry leaves only on a cycle
  // where both are high at the clock edge. Flush masks valid so nothing issues in that cycle.
  always_comb begin
    iss_valid   = '0;
    iss_src1    = '0;
    iss_src2    = '0;
    iss_dst     = '0;
    iss_rob     = '0;
    iss_payload = '0;
    for (int p = 0; p < 2; p++) begin
      iss_valid[p]                            = sel_found[p] && !flush;
      iss_src1[p*PREG_W +: PREG_W]            = ent_q[sel_idx[p]].src1;
      iss_src2[p*PREG_W +: PREG_W]            = ent_q[sel_idx[p]].src2;
      iss_dst[p*PREG_W +: PREG_W]             = ent_q[sel_idx[p]].dst;
      iss_rob[p*ROB_W +: ROB_W]               = ent_q[sel_idx[p]].rob;
      iss_payload[p*PAYLOAD_W +: PAYLOAD_W]   = ent_q[sel_idx[p]].payload;
    end
  end

  assign occupancy  = occ;
  assign disp_ready = !flush && ((CNT_W'(IQ_DEPTH) - occ) >= CNT_W'(2));

  always_comb begin
    new_e = '0;
    for (int i = 0; i < IQ_DEPTH; i++) begin
      ent_d[i] = ent_q[i];
      if (ent_q[i].valid) begin
        if (!ent_q[i].m1) begin
          if (wk_hit(ent_q[i].src1, wk_valid, wk_tag)) begin
            ent_d[i].m1 = 1'b1;
            ent_d[i].c1 = ent_q[i].dly1;
          end
        end else if (ent_q[i].c1 != '0) begin
          ent_d[i].c1 = ent_q[i].c1 - LAT_W'(1);
        end
        if (!ent_q[i].m2) begin
          if (wk_hit(ent_q[i].src2, wk_valid, wk_tag)) begin
            ent_d[i].m2 = 1'b1;
            ent_d[i].c2 = ent_q[i].dly2;
          end
        end else if (ent_q[i].c2 != '0) begin
          ent_d[i].c2 = ent_q[i].c2 - LAT_W'(1);
        end
        if (flush && is_older(flush_rob, flush_sb, ent_q[i].rob, ent_q[i].sb)) begin
          ent_d[i].valid = 1'b0;
        end
      end
    end
    for (int p = 0; p < 2; p++) begin
      if (iss_valid[p] && iss_ready[p]) begin
        ent_d[sel_idx[p]].valid = 1'b0;
      end
    end
    // Dispatching sources are compared against this cycle's broadcasts so no wakeup slips by.
    for (int k = 0; k < 2; k++) begin
      if (disp_ready && disp_valid[k]) begin
        new_e.valid   = 1'b1;
        new_e.port    = disp_port[k];
        new_e.src1    = disp_src1[k*PREG_W +: PREG_W];
        new_e.src2    = disp_src2[k*PREG_W +: PREG_W];
        new_e.dly1    = disp_dly1[k*LAT_W +: LAT_W];
        new_e.dly2    = disp_dly2[k*LAT_W +: LAT_W];
        new_e.m1      = disp_rdy1[k] || wk_hit(new_e.src1, wk_valid, wk_tag);
        new_e.m2      = disp_rdy2[k] || wk_hit(new_e.src2, wk_valid, wk_tag);
        new_e.c1      = disp_rdy1[k] ? '0 : (new_e.m1 ? new_e.dly1 : '0);
        new_e.c2      = disp_rdy2[k] ? '0 : (new_e.m2 ? new_e.dly2 : '0);
        new_e.dst     = disp_dst[k*PREG_W +: PREG_W];
        new_e.rob     = disp_rob[k*ROB_W +: ROB_W];
        new_e.sb      = disp_sb[k];
        new_e.payload = disp_payload[k*PAYLOAD_W +: PAYLOAD_W];
        ent_d[alloc_idx[k]] = new_e;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < IQ_DEPTH; i++) ent_q[i] <= '0;
    end else begin
      for (int i = 0; i < IQ_DEPTH; i++) ent_q[i] <= ent_d[i];
    end
  end
endmodule

// File: tb/tb_issue_queue_sel.sv
// Bench for issue_queue_sel: directed dispatch/wakeup/flush vectors, per-port expected queues
// popped by a monitor on every accepted issue.
`timescale 1ns/1ps
module tb_issue_queue_sel;
  localparam int IQ_DEPTH  = 16;
  localparam int PREG_W    = 6;
  localparam int ROB_W     = 6;
  localparam int LAT_W     = 3;
  localparam int PAYLOAD_W = 32;
  localparam int EW        = ROB_W + PREG_W + PAYLOAD_W;

  logic                   clk;
  logic                   reset_n;
  logic [1:0]             disp_valid;
  logic                   disp_ready;
  logic [1:0]             disp_port;
  logic [2*PREG_W-1:0]    disp_src1, disp_src2, disp_dst;
  logic [1:0]             disp_rdy1, disp_rdy2, disp_sb;
  logic [2*LAT_W-1:0]     disp_dly1, disp_dly2;
  logic [2*ROB_W-1:0]     disp_rob;
  logic [2*PAYLOAD_W-1:0] disp_payload;
  logic [1:0]             wk_valid;
  logic [2*PREG_W-1:0]    wk_tag;
  logic                   flush;
  logic [ROB_W-1:0]       flush_rob;
  logic                   flush_sb;
  logic [1:0]             iss_valid, iss_ready;
  logic [2*PREG_W-1:0]    iss_src1, iss_src2, iss_dst;
  logic [2*ROB_W-1:0]     iss_rob;
  logic [2*PAYLOAD_W-1:0] iss_payload;
  logic [4:0]             occupancy;

  issue_queue_sel #(
    .IQ_DEPTH(IQ_DEPTH), .PREG_W(PREG_W), .ROB_W(ROB_W), .LAT_W(LAT_W), .PAYLOAD_W(PAYLOAD_W)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .disp_valid(disp_valid), .disp_ready(disp_ready), .disp_port(disp_port),
    .disp_src1(disp_src1), .disp_src2(disp_src2), .disp_rdy1(disp_rdy1), .disp_rdy2(disp_rdy2),
    .disp_dly1(disp_dly1), .disp_dly2(disp_dly2), .disp_dst(disp_dst), .disp_rob(disp_rob),
    .disp_sb(disp_sb), .disp_payload(disp_payload),
    .wk_valid(wk_valid), .wk_tag(wk_tag),
    .flush(flush), .flush_rob(flush_rob), .flush_sb(flush_sb),
    .iss_valid(iss_valid), .iss_ready(iss_ready), .iss_src1(iss_src1), .iss_src2(iss_src2),
    .iss_dst(iss_dst), .iss_rob(iss_rob), .iss_payload(iss_payload), .occupancy(occupancy)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached before summary");
    $fatal(1);
  end

  int checks = 0;
  int errors = 0;
  logic [EW-1:0] exp_q0[$];
  logic [EW-1:0] exp_q1[$];

  function automatic logic [PREG_W-1:0] dst_of(input logic [ROB_W-1:0] r);
    return r ^ 6'h15;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push_exp(input int p, input logic [ROB_W-1:0] rob, input logic [PAYLOAD_W-1:0] pl);
    if (p == 0) exp_q0.push_back({rob, dst_of(rob), pl});
    else        exp_q1.push_back({rob, dst_of(rob), pl});
  endtask

  // driver tasks
  task automatic set_slot(input int k, input logic port, input logic [PREG_W-1:0] s1, input logic r1,
                          input logic [LAT_W-1:0] d1, input logic [PREG_W-1:0] s2, input logic r2,
                          input logic [ROB_W-1:0] rob, input logic sb, input logic [PAYLOAD_W-1:0] pl,
                          input logic expect_issue);
    disp_valid[k]                         = 1'b1;
    disp_port[k]                          = port;
    disp_src1[k*PREG_W +: PREG_W]         = s1;
    disp_rdy1[k]                          = r1;
    disp_dly1[k*LAT_W +: LAT_W]           = d1;
    disp_src2[k*PREG_W +: PREG_W]         = s2;
    disp_rdy2[k]                          = r2;
    disp_dly2[k*LAT_W +: LAT_W]           = '0;
    disp_dst[k*PREG_W +: PREG_W]          = dst_of(rob);
    disp_rob[k*ROB_W +: ROB_W]            = rob;
    disp_sb[k]                            = sb;
    disp_payload[k*PAYLOAD_W +: PAYLOAD_W] = pl;
    if (expect_issue) push_exp(int'(port), rob, pl);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    disp_valid = '0;
    wk_valid   = '0;
    flush      = 1'b0;
  endtask

  // scoreboard monitor
  task automatic sb_check(input int p, input logic [EW-1:0] act);
    logic [EW-1:0] exp;
    checks++;
    if ((p == 0 && exp_q0.size() == 0) || (p == 1 && exp_q1.size() == 0)) begin
      errors++;
      $display("FAIL issue_port%0d: got unexpected issue %0h, expected none", p, act);
    end else begin
      if (p == 0) exp = exp_q0.pop_front();
      else        exp = exp_q1.pop_front();
      if (act !== exp) begin
        errors++;
        $display("FAIL issue_port%0d: got %0h expected %0h", p, act, exp);
      end
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (reset_n) begin
        for (int p = 0; p < 2; p++) begin
          if (iss_valid[p] && iss_ready[p]) begin
            sb_check(p, {iss_rob[p*ROB_W +: ROB_W], iss_dst[p*PREG_W +: PREG_W],
                         iss_payload[p*PAYLOAD_W +: PAYLOAD_W]});
          end
        end
      end
    end
  end

  initial begin
    reset_n = 1'b0; disp_valid = '0; disp_port = '0; disp_src1 = '0; disp_src2 = '0;
    disp_rdy1 = '0; disp_rdy2 = '0; disp_dly1 = '0; disp_dly2 = '0; disp_dst = '0;
    disp_rob = '0; disp_sb = '0; disp_payload = '0; wk_valid = '0; wk_tag = '0;
    flush = 1'b0; flush_rob = '0; flush_sb = 1'b0; iss_ready = 2'b11;
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    @(negedge clk);
    chk("reset_occupancy", occupancy, 0);
    chk("reset_iss_valid", iss_valid, 0);
    chk("reset_disp_ready", disp_ready, 1);

    // two ready instructions, one per port
    set_slot(0, 1'b0, 6'd1, 1'b1, 3'd0, 6'd2, 1'b1, 6'd1, 1'b0, 32'h1111_0001, 1'b1);
    set_slot(1, 1'b1, 6'd3, 1'b1, 3'd0, 6'd4, 1'b1, 6'd2, 1'b0, 32'h1111_0002, 1'b1);
    tick(); @(negedge clk);
    chk("basic_occupancy", occupancy, 2);
    chk("basic_iss_valid", iss_valid, 2'b11);
    tick(); @(negedge clk);
    chk("basic_drained", occupancy, 0);

    // wakeup with dly=2: broadcast in cycle W, request in W+3
    set_slot(0, 1'b0, 6'd7, 1'b0, 3'd2, 6'd8, 1'b1, 6'd10, 1'b0, 32'h2222_0010, 1'b1);
    tick(); @(negedge clk);
    chk("wake_before_bcast", iss_valid[0], 0);
    wk_valid = 2'b01; wk_tag = {6'd0, 6'd7};
    tick(); @(negedge clk);
    chk("wake_lat_w1", iss_valid[0], 0);
    tick(); @(negedge clk);
    chk("wake_lat_w2", iss_valid[0], 0);
    tick(); @(negedge clk);
    chk("wake_lat_w3_valid", iss_valid[0], 1);
    chk("wake_lat_w3_rob", iss_rob[ROB_W-1:0], 10);
    tick();

    // same-cycle bypass of a broadcast into a dispatching source
    set_slot(0, 1'b0, 6'd9, 1'b0, 3'd0, 6'd12, 1'b1, 6'd11, 1'b0, 32'h3333_0011, 1'b1);
    wk_valid = 2'b10; wk_tag = {6'd9, 6'd0};
    tick(); @(negedge clk);
    chk("bypass_iss_valid", iss_valid[0], 1);
    chk("bypass_rob", iss_rob[ROB_W-1:0], 11);
    tick();

    // backpressure on port 0 for three cycles
    iss_ready = 2'b10;
    set_slot(0, 1'b0, 6'd1, 1'b1, 3'd0, 6'd2, 1'b1, 6'd20, 1'b0, 32'h4444_0020, 1'b1);
    tick();
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("bp_hold_valid", iss_valid[0], 1);
      chk("bp_hold_rob", iss_rob[ROB_W-1:0], 20);
      chk("bp_hold_occupancy", occupancy, 1);
      tick();
    end
    iss_ready = 2'b11;
    @(negedge clk);
    chk("bp_accept_occupancy", occupancy, 1);
    tick(); @(negedge clk);
    chk("bp_freed_occupancy", occupancy, 0);

    // select priority: index 0 (rob 5, sb 1) vs index 3 (rob 60, sb 0), both on port 1
    set_slot(0, 1'b1, 6'd30, 1'b0, 3'd0, 6'd2, 1'b1, 6'd5, 1'b1, 32'h5555_0005, 1'b0);
    set_slot(1, 1'b0, 6'd1, 1'b1, 3'd0, 6'd2, 1'b1, 6'd40, 1'b0, 32'h5555_0040, 1'b1);
    tick();
    set_slot(0, 1'b0, 6'd1, 1'b1, 3'd0, 6'd2, 1'b1, 6'd41, 1'b0, 32'h5555_0041, 1'b1);
    set_slot(1, 1'b1, 6'd30, 1'b0, 3'd0, 6'd2, 1'b1, 6'd60, 1'b0, 32'h5555_0060, 1'b0);
`ifdef ISSUE_QUEUE_AGE_SELECT_EN
    push_exp(1, 6'd60, 32'h5555_0060);
    push_exp(1, 6'd5, 32'h5555_0005);
`else
    push_exp(1, 6'd5, 32'h5555_0005);
    push_exp(1, 6'd60, 32'h5555_0060);
`endif
    tick();
    wk_valid = 2'b01; wk_tag = {6'd0, 6'd30};
    @(negedge clk);
    chk("age_port1_idle", iss_valid[1], 0);
    tick(); @(negedge clk);
    chk("age_occupancy", occupancy, 2);
`ifdef ISSUE_QUEUE_AGE_SELECT_EN
    chk("age_first_rob", iss_rob[2*ROB_W-1:ROB_W], 60);
`else
    chk("age_first_rob", iss_rob[2*ROB_W-1:ROB_W], 5);
`endif
    tick(); @(negedge clk);
`ifdef ISSUE_QUEUE_AGE_SELECT_EN
    chk("age_second_rob", iss_rob[2*ROB_W-1:ROB_W], 5);
`else
    chk("age_second_rob", iss_rob[2*ROB_W-1:ROB_W], 60);
`endif
    tick();

    // asynchronous reset with five presented-but-blocked entries
    iss_ready = 2'b00;
    set_slot(0, 1'b0, 6'd1, 1'b1, 3'd0, 6'd2, 1'b1, 6'd21, 1'b0, 32'h6666_0021, 1'b0);
    set_slot(1, 1'b1, 6'd1, 1'b1, 3'd0, 6'd2, 1'b1, 6'd22, 1'b0, 32'h6666_0022, 1'b0);
    tick();
    set_slot(0, 1'b0, 6'd1, 1'b1, 3'd0, 6'd2, 1'b1, 6'd23, 1'b0, 32'h6666_0023, 1'b0);
    set_slot(1, 1'b1, 6'd1, 1'b1, 3'd0, 6'd2, 1'b1, 6'd24, 1'b0, 32'h6666_0024, 1'b0);
    tick();
    set_slot(0, 1'b0, 6'd1, 1'b1, 3'd0, 6'd2, 1'b1, 6'd25, 1'b0, 32'h6666_0025, 1'b0);
    tick(); @(negedge clk);
    chk("rst_pre_occupancy", occupancy, 5);
    chk("rst_pre_iss_valid", iss_valid, 2'b11);
    #2 reset_n = 1'b0;
    #1;
    chk("rst_async_iss_valid", iss_valid, 0);
    chk("rst_async_occupancy", occupancy, 0);
    @(posedge clk);
    #2 reset_n = 1'b1;
    iss_ready = 2'b11;
    @(negedge clk);
    chk("rst_release_disp_ready", disp_ready, 1);
    chk("rst_release_iss_valid", iss_valid, 0);

    // fill all 16 entries with rob 0..15, then flush at rob 7
    for (int j = 0; j < 8; j++) begin
      set_slot(0, 1'b0, 6'd50, 1'b0, 3'd0, 6'd2, 1'b1, ROB_W'(2*j), 1'b0,
               32'hF000_0000 | 32'(2*j), (2*j) <= 7);
      set_slot(1, 1'b0, 6'd50, 1'b0, 3'd0, 6'd2, 1'b1, ROB_W'(2*j+1), 1'b0,
               32'hF000_0000 | 32'(2*j+1), (2*j+1) <= 7);
      tick();
    end
    @(negedge clk);
    chk("full_occupancy", occupancy, 16);
    chk("full_disp_ready", disp_ready, 0);
    set_slot(0, 1'b0, 6'd1, 1'b1, 3'd0, 6'd2, 1'b1, 6'd33, 1'b0, 32'hDEAD_0033, 1'b0);
    tick(); @(negedge clk);
    chk("full_ignore_occupancy", occupancy, 16);
    wk_valid = 2'b01; wk_tag = {6'd0, 6'd50};
    tick();
    flush = 1'b1; flush_rob = 6'd7; flush_sb = 1'b0;
    @(negedge clk);
    chk("flush_iss_valid", iss_valid, 0);
    chk("flush_disp_ready", disp_ready, 0);
    tick(); @(negedge clk);
    chk("post_flush_occupancy", occupancy, 8);
    chk("post_flush_disp_ready", disp_ready, 1);

    for (int c = 0; c < 40 && (exp_q0.size() != 0 || exp_q1.size() != 0); c++) @(negedge clk);
    repeat (3) @(negedge clk);
    chk("drain_port0_queue", exp_q0.size(), 0);
    chk("drain_port1_queue", exp_q1.size(), 0);
    chk("final_occupancy", occupancy, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
